layer_featuremap_acc: RTL and testbench
=======================================

LAYER_FEATUREMAP_ACC -- requirements
Module: layer_featuremap_acc

Interface
REQ-001 Parameter NUM_CH, 16, number of input channels summed into one output feature map; power of two, 2..64.
REQ-002 Parameter DATA_WIDTH, 16, width of each signed two's-complement fixed-point sample.
REQ-003 Parameter IMG_SIZE, 208, output feature-map side length in pixels; frame = IMG_SIZE*IMG_SIZE pixels.
REQ-004 Parameter BIAS, 0, signed DATA_WIDTH bias added once per output pixel.
REQ-005 Parameter ACT_MODE, 1, activation select: 0 linear, 1 leaky ReLU, 2 ReLU.
REQ-006 Parameter LEAKY_SHIFT, 3, arithmetic right-shift applied to negative values in leaky mode (slope 1/8).
REQ-007 Clk  input  1  single clock; all logic on rising edge.
REQ-008 Rst  input  1  reset, synchronous and active-high.
REQ-009 data_in  input  NUM_CH*DATA_WIDTH  per-channel 3x3 convolution results; channel k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 valid_in  input  1  data_in valid.
REQ-011 ready_in  output  1  block can accept data_in this cycle.
REQ-012 data_out  output  DATA_WIDTH  activated, saturated feature-map pixel.
REQ-013 valid_out  output  1  data_out valid.
REQ-014 ready_out  input  1  downstream accepts data_out.
REQ-015 last_out  output  1  high with valid_out on the final pixel of a frame.
REQ-016 sat_out  output  1  high with valid_out when the current pixel was saturated.

Function
REQ-017 Input transfer occurs when valid_in && ready_in; output transfer when valid_out && ready_out.
REQ-018 Stall = valid_out && !ready_out; ready_in SHALL equal !stall, combinationally.
REQ-019 Pipeline: L = log2(NUM_CH) registered adder-tree stages, then one registered bias/activation/saturation stage; latency L+1 cycles from input transfer to valid_out with no stall.
REQ-020 Each pipeline stage carries a valid bit; all stages advance only when !stall; stalled stages hold data and valid unchanged.
REQ-021 Tree stage i sums pairs at width DATA_WIDTH+i, sign-extended; no intermediate overflow possible.
REQ-022 Final stage: sum = tree result + sign-extended BIAS at width DATA_WIDTH+L+1.
REQ-023 Activation on full-width sum: mode 0 pass; mode 1 negative values arithmetic-shifted right LEAKY_SHIFT (round toward minus infinity); mode 2 negative values forced to 0.
REQ-024 Activated value saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; sat_out set iff clipping occurred.
REQ-025 Pixel counter counts output transfers 0..IMG_SIZE^2-1; last_out high when count = IMG_SIZE^2-1 and valid_out; counter wraps to 0 on that transfer.
REQ-026 Bubbles (valid_in low) propagate as invalid stages; the pixel counter does not advance on bubbles.
REQ-027 Simultaneous output transfer and input transfer in one cycle is lossless at full throughput (one pixel per cycle).

Reset
REQ-028 On Rst high at a clock edge: all stage valids, valid_out, last_out, sat_out, and pixel counter to 0; data_out to 0.
REQ-029 Reset mid-frame discards all in-flight pixels; the next accepted pixel starts a new frame at count 0.
REQ-030 ready_in SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-031 ACT_MODE encodings (linear/leaky/ReLU) and the saturation-bound helper belong in the shared layer package.
REQ-032 One sub-module, featuremap_adder_stage (one registered pairwise-add tree level with valid and enable), instantiated L times via generate.

Verification
REQ-033 NUM_CH=4, DATA_WIDTH=16, BIAS=10, ACT_MODE=1: all channels 100 -> data_out 410, valid_out exactly 3 cycles after input transfer.
REQ-034 Same config, BIAS=0: all channels -80 -> sum -320, data_out -40, sat_out 0; ACT_MODE=2 -> data_out 0.
REQ-035 All channels 32767, BIAS=0, ACT_MODE=0 -> data_out 32767, sat_out 1; all -32768 -> data_out -32768, sat_out 1.
REQ-036 Continuous stream of 20 pixels, ready_out low for 5 cycles mid-stream -> ready_in low those cycles, data_out held stable, all 20 outputs delivered in order, no loss or duplication.
REQ-037 IMG_SIZE=3: 20 pixels -> last_out on outputs 9 and 18 only; Rst asserted after output 4 of next frame -> valid_out 0 next cycle, following frame's last_out on its 9th output.

Source files
------------

// File: rtl/layer_featuremap_acc_pkg.sv
// Shared definitions for the feature-map accumulator: activation encodings and
// saturation-bound helpers used by the output stage.
package layer_featuremap_acc_pkg;

    typedef enum int unsigned {
        ActLinear = 0,
        ActLeaky  = 1,
        ActRelu   = 2
    } act_mode_e;

    // Largest value representable in a signed field of the given width.
    function automatic logic signed [63:0] sat_max(input int unsigned width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed field of the given width.
    function automatic logic signed [63:0] sat_min(input int unsigned width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/layer_featuremap_acc_adder.sv
// One registered level of the channel adder tree: adds adjacent input pairs with
// one bit of growth and advances only when enabled.
module featuremap_adder_stage #(
    parameter int unsigned IN_WIDTH = 16,
    parameter int unsigned NUM_IN   = 2
) (
    input  logic                                    Clk,
    input  logic                                    Rst,
    input  logic                                    en,
    input  logic                                    valid_in,
    input  logic [NUM_IN*IN_WIDTH-1:0]              data_in,
    output logic                                    valid_out,
    output logic [(NUM_IN/2)*(IN_WIDTH+1)-1:0]      data_out
);

    localparam int unsigned OutW   = IN_WIDTH + 1;
    localparam int unsigned NumOut = NUM_IN / 2;

    logic [NumOut*OutW-1:0] sum_d;

    always_comb begin
        sum_d = '0;
        for (int p = 0; p < NumOut; p++) begin
            sum_d[p*OutW +: OutW] =
                OutW'($signed(data_in[(2*p)*IN_WIDTH +: IN_WIDTH])) +
                OutW'($signed(data_in[(2*p+1)*IN_WIDTH +: IN_WIDTH]));
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (en) begin
            valid_out <= valid_in;
            data_out  <= sum_d;
        end
    end

endmodule

// File: rtl/layer_featuremap_acc.sv
// Sums NUM_CH per-channel convolution results through a registered adder tree, then adds
// bias, applies the activation and saturates to DATA_WIDTH, tracking frame position.
module layer_featuremap_acc
    import layer_featuremap_acc_pkg::*;
#(
    parameter int unsigned NUM_CH      = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned IMG_SIZE    = 208,
    parameter int          BIAS        = 0,
    parameter int unsigned ACT_MODE    = 1,
    parameter int unsigned LEAKY_SHIFT = 3
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         valid_in,
    output logic                         ready_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic                         last_out,
    output logic                         sat_out
);

    localparam int unsigned L     = $clog2(NUM_CH);
    localparam int unsigned TreeW = DATA_WIDTH + L;
    localparam int unsigned SumW  = TreeW + 1;
    localparam int unsigned Frame = IMG_SIZE * IMG_SIZE;
    localparam int unsigned CntW  = (Frame > 1) ? $clog2(Frame) : 1;

    // Bits produced by tree level i: half as many lanes, one bit wider.
    function automatic int unsigned stage_bits(input int unsigned i);
        return (NUM_CH >> (i + 1)) * (DATA_WIDTH + i + 1);
    endfunction

    function automatic int unsigned stage_off(input int unsigned i);
        int unsigned off;
        off = 0;
        for (int unsigned k = 0; k < i; k++) begin
            off += stage_bits(k);
        end
        return off;
    endfunction

    localparam int unsigned TotalW  = stage_off(L);
    localparam int unsigned TreeOff = stage_off(L - 1);

    localparam logic signed [DATA_WIDTH-1:0] BiasDw = DATA_WIDTH'(BIAS);
    localparam logic signed [SumW-1:0]       BiasExt = SumW'(BiasDw);
    localparam logic signed [SumW-1:0]       SatHi   = SumW'(sat_max(DATA_WIDTH));
    localparam logic signed [SumW-1:0]       SatLo   = SumW'(sat_min(DATA_WIDTH));

    logic                  stall;
    logic [TotalW-1:0]     tree_bus;
    logic [L-1:0]          tree_valid;
    logic signed [SumW-1:0] sum;
    logic signed [SumW-1:0] act;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  sat_d;
    logic [CntW-1:0]       pix_cnt;

    assign stall    = valid_out && !ready_out;
    assign ready_in = !stall;

    // Every level packs its lanes into tree_bus right after the previous level's lanes.
    for (genvar i = 0; i < L; i++) begin : g_tree
        localparam int unsigned InW = DATA_WIDTH + i;
        localparam int unsigned NIn = NUM_CH >> i;

        logic [NIn*InW-1:0] stage_in;
        logic               stage_vin;

        if (i == 0) begin : g_first
            assign stage_in  = data_in;
            assign stage_vin = valid_in;
        end else begin : g_next
            assign stage_in  = tree_bus[stage_off(i - 1) +: NIn*InW];
            assign stage_vin = tree_valid[i-1];
        end

        featuremap_adder_stage #(
            .IN_WIDTH (InW),
            .NUM_IN   (NIn)
        ) u_stage (
            .Clk       (Clk),
            .Rst       (Rst),
            .en        (!stall),
            .valid_in  (stage_vin),
            .data_in   (stage_in),
            .valid_out (tree_valid[i]),
            .data_out  (tree_bus[stage_off(i) +: stage_bits(i)])
        );
    end

    assign sum = SumW'($signed(tree_bus[TreeOff +: TreeW])) + BiasExt;

    always_comb begin
        act = sum;
        if (sum[SumW-1]) begin
            if (ACT_MODE == ActLeaky) begin
                act = sum >>> LEAKY_SHIFT;
            end else if (ACT_MODE == ActRelu) begin
                act = '0;
            end
        end

        sat_d = 1'b1;
        if (act > SatHi) begin
            data_d = SatHi[DATA_WIDTH-1:0];
        end else if (act < SatLo) begin
            data_d = SatLo[DATA_WIDTH-1:0];
        end else begin
            data_d = act[DATA_WIDTH-1:0];
            sat_d  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            sat_out   <= 1'b0;
        end else if (!stall) begin
            valid_out <= tree_valid[L-1];
            sat_out   <= tree_valid[L-1] && sat_d;
            if (tree_valid[L-1]) begin
                data_out <= data_d;
            end
        end
    end

    assign last_out = valid_out && (pix_cnt == CntW'(Frame - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pix_cnt <= '0;
        end else if (valid_out && ready_out) begin
            pix_cnt <= last_out ? '0 : pix_cnt + CntW'(1);
        end
    end

endmodule

// File: tb/tb_layer_featuremap_acc.sv
// Bench for layer_featuremap_acc: four configurations share stimulus; the main one is
// scored against an arithmetic reference model.
module tb_layer_featuremap_acc;

    localparam int unsigned Img = 3;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [63:0] data_in;
    logic        valid_in;
    logic        ready_out;

    logic        ready_in_a, valid_out_a, last_out_a, sat_out_a;
    logic        ready_in_b, valid_out_b, last_out_b, sat_out_b;
    logic        ready_in_c, valid_out_c, last_out_c, sat_out_c;
    logic        ready_in_d, valid_out_d, last_out_d, sat_out_d;
    logic [15:0] data_out_a, data_out_b, data_out_c, data_out_d;

    int total = 0;
    int bad   = 0;

    int exp_data[$];
    bit exp_sat[$];
    int got_data[$];
    bit got_sat[$];
    bit got_last[$];
    int out_pos = 0;
    int mv;
    bit ms;

    always #5 Clk = ~Clk;

    // a: bias 10 leaky (scored), b: bias 0 leaky, c: bias 0 relu, d: bias 0 linear
    layer_featuremap_acc #(.NUM_CH(4), .DATA_WIDTH(16), .IMG_SIZE(Img), .BIAS(10),
        .ACT_MODE(1), .LEAKY_SHIFT(3)) dut_a (
        .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in_a),
        .data_out(data_out_a), .valid_out(valid_out_a), .ready_out(ready_out),
        .last_out(last_out_a), .sat_out(sat_out_a));
    layer_featuremap_acc #(.NUM_CH(4), .DATA_WIDTH(16), .IMG_SIZE(Img), .BIAS(0),
        .ACT_MODE(1), .LEAKY_SHIFT(3)) dut_b (
        .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in_b),
        .data_out(data_out_b), .valid_out(valid_out_b), .ready_out(ready_out),
        .last_out(last_out_b), .sat_out(sat_out_b));
    layer_featuremap_acc #(.NUM_CH(4), .DATA_WIDTH(16), .IMG_SIZE(Img), .BIAS(0),
        .ACT_MODE(2), .LEAKY_SHIFT(3)) dut_c (
        .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in_c),
        .data_out(data_out_c), .valid_out(valid_out_c), .ready_out(ready_out),
        .last_out(last_out_c), .sat_out(sat_out_c));
    layer_featuremap_acc #(.NUM_CH(4), .DATA_WIDTH(16), .IMG_SIZE(Img), .BIAS(0),
        .ACT_MODE(0), .LEAKY_SHIFT(3)) dut_d (
        .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in_d),
        .data_out(data_out_d), .valid_out(valid_out_d), .ready_out(ready_out),
        .last_out(last_out_d), .sat_out(sat_out_d));

    // Reference: integer sum plus bias, floor-divide by 8 for leaky, clip to 16 bits.
    function automatic void model(input logic [63:0] d, input int bias, input int mode,
                                  output int val, output bit sat);
        int s;
        int a;
        s = bias;
        for (int k = 0; k < 4; k++) s += int'($signed(d[k*16 +: 16]));
        a = s;
        if (s < 0 && mode == 1) a = (s - 7) / 8;
        else if (s < 0 && mode == 2) a = 0;
        sat = 1'b0;
        val = a;
        if (a > 32767) begin val = 32767; sat = 1'b1; end
        else if (a < -32768) begin val = -32768; sat = 1'b1; end
    endfunction

    function automatic logic [63:0] rand_pixel();
        logic [63:0] d;
        d = '0;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(1, 0) == 1) d[k*16 +: 16] = 16'($urandom);
            else d[k*16 +: 16] = 16'($urandom_range(400, 0)) - 16'd200;
        end
        return d;
    endfunction

    // Scoreboard capture for dut_a; a reset drops whatever was still in flight.
    always @(negedge Clk) begin
        if (Rst) begin
            while (exp_data.size() > got_data.size()) begin
                void'(exp_data.pop_back());
                void'(exp_sat.pop_back());
            end
            out_pos = 0;
        end else begin
            if (valid_in && ready_in_a) begin
                model(data_in, 10, 1, mv, ms);
                exp_data.push_back(mv);
                exp_sat.push_back(ms);
            end
            if (valid_out_a && ready_out) begin
                got_data.push_back(int'($signed(data_out_a)));
                got_sat.push_back(sat_out_a);
                got_last.push_back(last_out_a);
                out_pos = (out_pos == Img * Img - 1) ? 0 : out_pos + 1;
            end
        end
    end

    task automatic clear_q();
        exp_data.delete(); exp_sat.delete();
        got_data.delete(); got_sat.delete(); got_last.delete();
    endtask

    task automatic drain();
        @(posedge Clk); #1;
        valid_in = 1'b0;
        ready_out = 1'b1;
        repeat (8) @(posedge Clk);
    endtask

    task automatic send_pixel(input logic [63:0] d);
        @(posedge Clk); #1;
        data_in = d;
        valid_in = 1'b1;
        @(posedge Clk); #1;
        valid_in = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        total++; if (valid_out_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out_a); end
        total++; if (data_out_a !== 16'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_out_a); end
        total++; if (sat_out_a !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", sat_out_a); end
        total++; if (last_out_a !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", last_out_a); end
        total++; if (ready_in_a !== 1'b1) begin bad++; $display("FAIL reset_ready_in got=%b exp=1", ready_in_a); end
    endtask

    task automatic test_latency();
        int lat;
        lat = 0;
        @(posedge Clk); #1;
        data_in = {4{16'd100}};
        valid_in = 1'b1;
        @(posedge Clk); #1;
        valid_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clk);
            if (valid_out_a === 1'b1) begin lat = k; break; end
        end
        total++; if (lat != 3) begin bad++; $display("FAIL latency got=%0d exp=3", lat); end
        total++; if ($signed(data_out_a) !== 410) begin bad++; $display("FAIL bias_leaky_pos got=%0d exp=410", $signed(data_out_a)); end
        total++; if ($signed(data_out_d) !== 400) begin bad++; $display("FAIL linear_pos got=%0d exp=400", $signed(data_out_d)); end
        total++; if ($signed(data_out_c) !== 400) begin bad++; $display("FAIL relu_pos got=%0d exp=400", $signed(data_out_c)); end
        @(negedge Clk);
        total++; if (valid_out_a !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b exp=0", valid_out_a); end
    endtask

    task automatic test_leaky_relu();
        logic [15:0] c;
        logic [63:0] d;
        int v;
        bit s;
        c = -16'sd80;
        d = {4{c}};
        send_pixel(d);
        model(d, 10, 1, v, s);
        total++; if (valid_out_b !== 1'b1) begin bad++; $display("FAIL neg_valid got=%b exp=1", valid_out_b); end
        total++; if ($signed(data_out_b) !== -40) begin bad++; $display("FAIL leaky_neg got=%0d exp=-40", $signed(data_out_b)); end
        total++; if (sat_out_b !== 1'b0) begin bad++; $display("FAIL leaky_neg_sat got=%b exp=0", sat_out_b); end
        total++; if ($signed(data_out_c) !== 0) begin bad++; $display("FAIL relu_neg got=%0d exp=0", $signed(data_out_c)); end
        total++; if ($signed(data_out_d) !== -320) begin bad++; $display("FAIL linear_neg got=%0d exp=-320", $signed(data_out_d)); end
        total++; if ($signed(data_out_a) !== v) begin bad++; $display("FAIL leaky_bias_neg got=%0d exp=%0d", $signed(data_out_a), v); end
    endtask

    task automatic test_saturation();
        send_pixel({4{16'h7fff}});
        total++; if (data_out_d !== 16'h7fff || sat_out_d !== 1'b1) begin bad++; $display("FAIL sat_pos got=%h/%b exp=7fff/1", data_out_d, sat_out_d); end
        total++; if (data_out_c !== 16'h7fff || sat_out_c !== 1'b1) begin bad++; $display("FAIL relu_sat_pos got=%h/%b exp=7fff/1", data_out_c, sat_out_c); end
        send_pixel({4{16'h8000}});
        total++; if (data_out_d !== 16'h8000 || sat_out_d !== 1'b1) begin bad++; $display("FAIL sat_neg got=%h/%b exp=8000/1", data_out_d, sat_out_d); end
        total++; if ($signed(data_out_b) !== -16384 || sat_out_b !== 1'b0) begin bad++; $display("FAIL leaky_min got=%0d/%b exp=-16384/0", $signed(data_out_b), sat_out_b); end
        total++; if (data_out_c !== 16'h0000 || sat_out_c !== 1'b0) begin bad++; $display("FAIL relu_min got=%h/%b exp=0000/0", data_out_c, sat_out_c); end
    endtask

    task automatic test_random();
        drain();
        clear_q();
        for (int n = 0; n < 80; n++) begin
            @(posedge Clk); #1;
            valid_in = ($urandom_range(9, 0) < 7);
            ready_out = ($urandom_range(3, 0) != 0);
            data_in = rand_pixel();
        end
        drain();
        total++; if (got_data.size() != exp_data.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            total++;
            if (got_data[i] != exp_data[i] || got_sat[i] != exp_sat[i]) begin
                bad++;
                $display("FAIL rand_pixel[%0d] got=%0d/%b exp=%0d/%b", i, got_data[i], got_sat[i], exp_data[i], exp_sat[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] pix [20];
        logic [15:0] held;
        bit held_ok;
        int sent;
        int c;
        held_ok = 1'b0;
        held = '0;
        sent = 0;
        c = 0;
        drain();
        clear_q();
        for (int i = 0; i < 20; i++) pix[i] = rand_pixel();
        while (sent < 20 && c < 200) begin
            @(posedge Clk); #1;
            ready_out = !(c >= 8 && c < 13);
            valid_in = 1'b1;
            data_in = pix[sent];
            @(negedge Clk);
            if (!ready_out) begin
                total++; if (ready_in_a !== 1'b0) begin bad++; $display("FAIL stall_ready_in c=%0d got=%b exp=0", c, ready_in_a); end
                if (!held_ok) begin
                    held = data_out_a;
                    held_ok = 1'b1;
                end else begin
                    total++; if (data_out_a !== held) begin bad++; $display("FAIL stall_hold c=%0d got=%h exp=%h", c, data_out_a, held); end
                end
            end
            if (ready_in_a === 1'b1) sent++;
            c++;
        end
        drain();
        total++; if (got_data.size() != 20) begin bad++; $display("FAIL b2b_count got=%0d exp=20", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            total++;
            if (got_data[i] != exp_data[i]) begin bad++; $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, got_data[i], exp_data[i]); end
        end
    endtask

    task automatic test_frame();
        int guard;
        drain();
        @(posedge Clk); #1 Rst = 1'b1;
        @(posedge Clk); #1 Rst = 1'b0;
        clear_q();
        for (int n = 0; n < 20; n++) begin
            @(posedge Clk); #1;
            valid_in = 1'b1;
            data_in = rand_pixel();
        end
        drain();
        total++; if (got_data.size() != 20) begin bad++; $display("FAIL frame_count got=%0d exp=20", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            total++;
            if (got_last[i] != (i == 8 || i == 17) || got_data[i] != exp_data[i]) begin
                bad++;
                $display("FAIL frame_out[%0d] got=%0d/last%b exp=%0d/last%b", i, got_data[i], got_last[i], exp_data[i], (i == 8 || i == 17));
            end
        end
        clear_q();
        // two more outputs complete the fourth pixel of the third frame
        guard = 0;
        while (guard < 40) begin
            @(posedge Clk); #1;
            if (got_data.size() >= 2) break;
            valid_in = 1'b1;
            data_in = rand_pixel();
            guard++;
        end
        total++; if (got_data.size() < 2) begin bad++; $display("FAIL midframe_timeout got=%0d exp=2", got_data.size()); end
        Rst = 1'b1;
        valid_in = 1'b0;
        @(posedge Clk); #1 Rst = 1'b0;
        @(negedge Clk);
        total++; if (valid_out_a !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", valid_out_a); end
        clear_q();
        for (int n = 0; n < 9; n++) begin
            @(posedge Clk); #1;
            valid_in = 1'b1;
            data_in = rand_pixel();
        end
        drain();
        total++; if (got_data.size() != 9) begin bad++; $display("FAIL newframe_count got=%0d exp=9", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            total++;
            if (got_last[i] != (i == 8) || got_data[i] != exp_data[i]) begin
                bad++;
                $display("FAIL newframe_out[%0d] got=%0d/last%b exp=%0d/last%b", i, got_data[i], got_last[i], exp_data[i], (i == 8));
            end
        end
    endtask

    initial begin
        Rst = 1'b1;
        valid_in = 1'b0;
        ready_out = 1'b1;
        data_in = '0;
        test_reset();
        test_latency();
        test_leaky_relu();
        test_saturation();
        test_random();
        test_back_to_back();
        test_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
